acq_timing_manager: RTL and testbench

- Parametrised successor to the fixed six-sensor timing manager: N_CH generic sensor channels, configurable counter widths.
- Generates the carrier-synchronous trigger and opens an acquisition window on each trigger.
- Captures per-channel done latency within the window, then issues a single-cycle scheduler interrupt.
- Adds over the previous generation: sticky done flags, enable snapshot at trigger, window timeout with missed-channel report, and trigger-overrun detection.
- Sits between the PWM carrier event source, the sensor interface IPs and the AXI register file.

---
 rtl/acq_tm_pkg.sv | 17 +
 rtl/acq_tm_channel.sv | 55 +++++
 rtl/acq_timing_manager.sv | 149 ++++++++++++++
 tb/tb_acq_timing_manager.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_tm_pkg.sv
// rtl/acq_tm_pkg.sv - shared types and defaults for the acquisition timing manager
package acq_tm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        DONE = 2'd2
    } acq_state_t;

    localparam int DEF_N_CH    = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_RATIO_W = 16;

    // Edge flops come out of reset high so a level already asserted is not an edge
    localparam logic EDGE_RST = 1'b1;

endpackage

// File: rtl/acq_tm_channel.sv
// rtl/acq_tm_channel.sv - per-channel done edge detect, sticky flag and time capture (ACQ_TIME_MAX_EN adds running max)
module acq_tm_channel
    import acq_tm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done_in,
    input  logic             en,
    input  logic             start,
    input  logic             cap_en,
`ifdef ACQ_TIME_MAX_EN
    input  logic             clr_max,
    output logic [CNT_W-1:0] ch_time_max,
`endif
    input  logic [CNT_W-1:0] count_time,
    output logic             sticky,
    output logic             hit,
    output logic [CNT_W-1:0] ch_time
);

    logic done_q;

    assign hit = cap_en & en & done_in & ~done_q & ~sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= EDGE_RST;
            sticky  <= 1'b0;
            ch_time <= '0;
        end else begin
            done_q <= done_in;
            if (start) begin
                sticky <= 1'b0;
            end else if (hit) begin
                sticky  <= 1'b1;
                ch_time <= count_time;
            end
        end
    end

`ifdef ACQ_TIME_MAX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_time_max <= '0;
        end else if (clr_max) begin
            ch_time_max <= '0;
        end else if (hit && (count_time > ch_time_max)) begin
            ch_time_max <= count_time;
        end
    end
`endif

endmodule

// File: rtl/acq_timing_manager.sv
// rtl/acq_timing_manager.sv - carrier-synchronous trigger, acquisition window FSM and latency capture (optional ACQ_TIME_MAX_EN)
module acq_timing_manager
    import acq_tm_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int RATIO_W = DEF_RATIO_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  event_qualifier,
    input  logic [RATIO_W-1:0]    user_ratio,
    input  logic [N_CH-1:0]       en_bits,
    input  logic [N_CH-1:0]       done_in,
    input  logic [CNT_W-1:0]      timeout_cycles,
    input  logic                  clr_flags,
    output logic                  trigger,
    output logic [N_CH-1:0]       en_out,
    output logic [N_CH*CNT_W-1:0] ch_time,
    output logic                  all_done,
    output logic                  sched_isr,
    output logic                  timeout_flag,
    output logic [N_CH-1:0]       ch_missed,
    output logic                  overrun,
`ifdef ACQ_TIME_MAX_EN
    output logic [N_CH*CNT_W-1:0] ch_time_max,
`endif
    output logic                  busy
);

    logic [RATIO_W-1:0] count;
    logic [CNT_W-1:0]   count_time;
    acq_state_t         state, state_n;
    logic [N_CH-1:0]    sticky, hit, done_mask;
    logic [N_CH-1:0]    en_n, missed_n;
    logic               all_done_n, sched_n, to_n, ovr_n;
    logic               complete, cap_en;

    // Count wraps naturally if user_ratio drops below the current count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            trigger <= 1'b0;
        end else if (event_qualifier) begin
            if (count == user_ratio) begin
                count   <= '0;
                trigger <= 1'b1;
            end else begin
                count   <= count + RATIO_W'(1);
                trigger <= 1'b0;
            end
        end else begin
            trigger <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_time <= '0;
        end else if (trigger) begin
            count_time <= '0;
        end else if (count_time != {CNT_W{1'b1}}) begin
            count_time <= count_time + CNT_W'(1);
        end
    end

    assign cap_en = (state == ACQ) && !trigger;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            acq_tm_channel #(.CNT_W(CNT_W)) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .done_in    (done_in[i]),
                .en         (en_out[i]),
                .start      (trigger),
                .cap_en     (cap_en),
`ifdef ACQ_TIME_MAX_EN
                .clr_max    (clr_flags),
                .ch_time_max(ch_time_max[i*CNT_W +: CNT_W]),
`endif
                .count_time (count_time),
                .sticky     (sticky[i]),
                .hit        (hit[i]),
                .ch_time    (ch_time[i*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Include this cycle's captures so the final edge completes the window at once
    assign done_mask = sticky | hit;
    assign complete  = &(done_mask | ~en_out);
    assign busy      = (state == ACQ);

    always_comb begin
        state_n    = state;
        en_n       = en_out;
        all_done_n = all_done;
        sched_n    = 1'b0;
        to_n       = timeout_flag;
        missed_n   = ch_missed;
        ovr_n      = overrun;
        if (clr_flags) begin
            ovr_n = 1'b0;
        end
        if (trigger) begin
            state_n    = ACQ;
            en_n       = en_bits;
            all_done_n = 1'b0;
            to_n       = 1'b0;
            missed_n   = '0;
            if (state == ACQ) begin
                ovr_n = 1'b1;
            end
        end else if (state == ACQ) begin
            if (complete) begin
                state_n    = DONE;
                all_done_n = 1'b1;
                sched_n    = 1'b1;
            end else if ((timeout_cycles != '0) && (count_time == timeout_cycles)) begin
                state_n  = DONE;
                to_n     = 1'b1;
                missed_n = en_out & ~done_mask;
                sched_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            en_out       <= '0;
            all_done     <= 1'b0;
            sched_isr    <= 1'b0;
            timeout_flag <= 1'b0;
            ch_missed    <= '0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_n;
            en_out       <= en_n;
            all_done     <= all_done_n;
            sched_isr    <= sched_n;
            timeout_flag <= to_n;
            ch_missed    <= missed_n;
            overrun      <= ovr_n;
        end
    end

endmodule

// File: tb/tb_acq_timing_manager.sv
// tb/tb_acq_timing_manager.sv - self-checking bench for acq_timing_manager (optional ACQ_TIME_MAX_EN checks)
module tb_acq_timing_manager;

    localparam int N_CH    = 8;
    localparam int CNT_W   = 16;
    localparam int RATIO_W = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  event_qualifier = 1'b0;
    logic [RATIO_W-1:0]    user_ratio = '0;
    logic [N_CH-1:0]       en_bits = '0;
    logic [N_CH-1:0]       done_in = '0;
    logic [CNT_W-1:0]      timeout_cycles = '0;
    logic                  clr_flags = 1'b0;
    logic                  trigger;
    logic [N_CH-1:0]       en_out;
    logic [N_CH*CNT_W-1:0] ch_time;
    logic                  all_done, sched_isr, timeout_flag, overrun, busy;
    logic [N_CH-1:0]       ch_missed;
`ifdef ACQ_TIME_MAX_EN
    logic [N_CH*CNT_W-1:0] ch_time_max;
`endif

    acq_timing_manager #(.N_CH(N_CH), .CNT_W(CNT_W), .RATIO_W(RATIO_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .event_qualifier(event_qualifier),
        .user_ratio     (user_ratio),
        .en_bits        (en_bits),
        .done_in        (done_in),
        .timeout_cycles (timeout_cycles),
        .clr_flags      (clr_flags),
        .trigger        (trigger),
        .en_out         (en_out),
        .ch_time        (ch_time),
        .all_done       (all_done),
        .sched_isr      (sched_isr),
        .timeout_flag   (timeout_flag),
        .ch_missed      (ch_missed),
        .overrun        (overrun),
`ifdef ACQ_TIME_MAX_EN
        .ch_time_max    (ch_time_max),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       en;
        logic [15:0]      to;
        logic [7:0][7:0]  done_at;
        logic [7:0]       cap;
        logic [7:0][15:0] exp_time;
        logic             all_done;
        logic             to_flag;
        logic [7:0]       missed;
        logic [7:0]       isr_k;
    } case_t;

    case_t tbl[7];
    case_t sb_q[$];
    case_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int    win_k  = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire();
        event_qualifier = 1'b1;
        tick();
        event_qualifier = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && sched_isr) begin
            if (sb_q.size() == 0) begin
                chk("isr_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("isr_cycle", 64'(win_k), 64'(mon_e.isr_k));
                chk("all_done", all_done, mon_e.all_done);
                chk("timeout_flag", timeout_flag, mon_e.to_flag);
                chk("ch_missed", ch_missed, mon_e.missed);
                chk("en_out", en_out, mon_e.en);
                chk("overrun_clear", overrun, 1'b0);
                chk("busy_done", busy, 1'b0);
                for (int i = 0; i < N_CH; i++)
                    if (mon_e.cap[i])
                        chk($sformatf("ch_time%0d", i), ch_time[i*CNT_W +: CNT_W], mon_e.exp_time[i]);
            end
        end
    end

    task automatic run_case(input case_t c);
        done_in        = '0;
        en_bits        = c.en;
        timeout_cycles = c.to;
        tick();
        tick();
        sb_q.push_back(c);
        fire();
        tick();
        for (int k = 0; k <= int'(c.isr_k) + 2; k++) begin
            win_k = k;
            for (int i = 0; i < N_CH; i++)
                if (int'(c.done_at[i]) == k) done_in[i] = 1'b1;
            tick();
        end
        chk("isr_seen", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 7; i++) begin
            tbl[i] = '0;
            tbl[i].done_at = '1;
        end
        tbl[0].en = 8'h05; tbl[0].done_at[0] = 8'd20; tbl[0].done_at[2] = 8'd35;
        tbl[0].cap = 8'h05; tbl[0].exp_time[0] = 16'd20; tbl[0].exp_time[2] = 16'd35;
        tbl[0].all_done = 1'b1; tbl[0].isr_k = 8'd36;
        tbl[1].en = 8'h03; tbl[1].to = 16'd50; tbl[1].done_at[0] = 8'd10;
        tbl[1].cap = 8'h01; tbl[1].exp_time[0] = 16'd10;
        tbl[1].to_flag = 1'b1; tbl[1].missed = 8'h02; tbl[1].isr_k = 8'd51;
        tbl[2].en = 8'h00; tbl[2].all_done = 1'b1; tbl[2].isr_k = 8'd1;
        tbl[3].en = 8'hFF; tbl[3].cap = 8'hFF;
        tbl[3].done_at  = {8'd31, 8'd27, 8'd23, 8'd19, 8'd15, 8'd11, 8'd7, 8'd3};
        tbl[3].exp_time = {16'd31, 16'd27, 16'd23, 16'd19, 16'd15, 16'd11, 16'd7, 16'd3};
        tbl[3].all_done = 1'b1; tbl[3].isr_k = 8'd32;
        tbl[4].en = 8'h81; tbl[4].to = 16'd40; tbl[4].done_at[0] = 8'd5; tbl[4].done_at[7] = 8'd40;
        tbl[4].cap = 8'h81; tbl[4].exp_time[0] = 16'd5; tbl[4].exp_time[7] = 16'd40;
        tbl[4].all_done = 1'b1; tbl[4].isr_k = 8'd41;
        tbl[5].en = 8'h06; tbl[5].to = 16'd30; tbl[5].done_at[1] = 8'd30;
        tbl[5].cap = 8'h02; tbl[5].exp_time[1] = 16'd30;
        tbl[5].to_flag = 1'b1; tbl[5].missed = 8'h04; tbl[5].isr_k = 8'd31;
        tbl[6].en = 8'h10; tbl[6].done_at[3] = 8'd5; tbl[6].done_at[4] = 8'd0;
        tbl[6].cap = 8'h10; tbl[6].exp_time[4] = 16'd0;
        tbl[6].all_done = 1'b1; tbl[6].isr_k = 8'd1;

        repeat (3) tick();
        chk("rst_trigger", trigger, 1'b0);
        chk("rst_en_out", en_out, '0);
        chk("rst_ch_time", 64'(ch_time != '0), 64'd0);
        chk("rst_flags", {all_done, sched_isr, timeout_flag, overrun, busy}, 5'b0);
        chk("rst_missed", ch_missed, '0);
        rst_n = 1'b1;
        tick();

        // trigger generator: one trigger per four qualifiers, one cycle wide
        user_ratio = 16'd3;
        for (int q = 0; q < 8; q++) begin
            fire();
            chk($sformatf("trig_q%0d", q), trigger, 1'((q % 4) == 3));
            tick();
            chk($sformatf("trig_low_q%0d", q), trigger, 1'b0);
            repeat (8) tick();
        end
        user_ratio = 16'd0;

        mon_en = 1'b1;
        for (int t = 0; t < 7; t++) run_case(tbl[t]);
        mon_en = 1'b0;

        // overrun with a coincident clr_flags; window restarts from zero
        done_in = '0; en_bits = 8'h03; timeout_cycles = '0;
        tick();
        fire(); tick();
        repeat (5) tick();
        done_in[0] = 1'b1;
        repeat (15) tick();
        fire();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_busy", busy, 1'b1);
        chk("ovr_keep_time0", ch_time[0 +: CNT_W], 16'd5);
        done_in[0] = 1'b0;
        repeat (3) tick();
        done_in[0] = 1'b1;
        repeat (4) tick();
        done_in[1] = 1'b1;
        tick();
        chk("ovr_isr", sched_isr, 1'b1);
        chk("ovr_all_done", all_done, 1'b1);
        chk("ovr_time0", ch_time[0 +: CNT_W], 16'd3);
        chk("ovr_time1", ch_time[CNT_W +: CNT_W], 16'd7);
        tick();
        chk("ovr_isr_single", sched_isr, 1'b0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);

        // second edge on a channel within the window is ignored
        done_in = '0; en_bits = 8'h03;
        tick();
        fire(); tick();
        repeat (5) tick();
        done_in[1] = 1'b1;
        repeat (5) tick();
        done_in[1] = 1'b0;
        repeat (5) tick();
        done_in[1] = 1'b1;
        repeat (10) tick();
        done_in[0] = 1'b1;
        tick();
        chk("dbl_isr", sched_isr, 1'b1);
        chk("dbl_time1", ch_time[CNT_W +: CNT_W], 16'd5);
        chk("dbl_time0", ch_time[0 +: CNT_W], 16'd25);
        tick();
        chk("dbl_hold_all_done", {all_done, sched_isr}, 2'b10);

        // reset mid-window with done held high across reset release
        done_in = '0; en_bits = 8'h01;
        tick();
        fire(); tick();
        repeat (5) tick();
        rst_n = 1'b0;
        done_in[0] = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_time", 64'(ch_time != '0), 64'd0);
        tick();
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (4) begin tick(); seen = seen | sched_isr; end
            chk("mid_rst_no_isr", seen, 1'b0);
        end
        timeout_cycles = 16'd20;
        fire(); tick();
        repeat (21) tick();
        chk("hi_rst_isr", sched_isr, 1'b1);
        chk("hi_rst_timeout", timeout_flag, 1'b1);
        chk("hi_rst_missed", ch_missed, 8'h01);
        chk("hi_rst_all_done", all_done, 1'b0);

        // done edge coinciding with trigger is discarded
        done_in = '0; timeout_cycles = 16'd10;
        tick();
        fire();
        done_in[0] = 1'b1;
        tick();
        repeat (11) tick();
        chk("trg_edge_isr", sched_isr, 1'b1);
        chk("trg_edge_timeout", timeout_flag, 1'b1);
        chk("trg_edge_missed", ch_missed, 8'h01);

`ifdef ACQ_TIME_MAX_EN
        done_in = '0; timeout_cycles = '0; en_bits = 8'h01;
        tick();
        fire(); tick();
        repeat (30) tick();
        done_in[0] = 1'b1;
        repeat (3) tick();
        done_in = '0;
        tick();
        fire(); tick();
        repeat (12) tick();
        done_in[0] = 1'b1;
        repeat (3) tick();
        chk("max_time0", ch_time[0 +: CNT_W], 16'd12);
        chk("max_keep", ch_time_max[0 +: CNT_W], 16'd30);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("max_clr", ch_time_max[0 +: CNT_W], 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
